// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter -- round-robin owner of the shared FIFO write port, bounded by burst/packet end.
// Rev 1.0
`default_nettype none

module fifo_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 6,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ack,
  input  logic                  fifo_ready,
  output logic                  fifo_write_en,
  output logic [WIDTH-1:0]      fifo_data,
  output logic [IDX_W-1:0]      grant_id,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  rr_ptr, rr_nx;
  logic [IDX_W-1:0]  grant_nx;
  logic [CNT_W-1:0]  burst_cnt, burst_nx;
  logic              busy_nx;
  logic              wen_nx;
  logic [WIDTH-1:0]  data_nx;

  logic              found;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W:0]    cand;
  logic              own_valid;
  logic              own_last;
  logic [WIDTH-1:0]  own_data;
  logic              xfer;
  logic              release_now;

  // Rotating priority scan starting at rr_ptr; modulo keeps indices below NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) cand = cand - (IDX_W+1)'(NREQ);
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    own_valid = req_valid[grant_id];
    own_last  = req_last[grant_id];
    own_data  = req_data[int'(grant_id)*WIDTH +: WIDTH];
    xfer      = (state == OWN) && own_valid && fifo_ready;
  end

  always_comb begin
    req_ack = '0;
    if (reset_n && xfer) req_ack[grant_id] = 1'b1;
  end

  always_comb begin
    state_nx    = state;
    rr_nx       = rr_ptr;
    grant_nx    = grant_id;
    burst_nx    = burst_cnt;
    busy_nx     = busy;
    wen_nx      = 1'b0;
    data_nx     = fifo_data;
    release_now = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          state_nx = OWN;
          grant_nx = pick;
          busy_nx  = 1'b1;
          burst_nx = '0;
        end
      end
      OWN: begin
        if (!own_valid) begin
          release_now = 1'b1;
        end else if (fifo_ready) begin
          wen_nx   = 1'b1;
          data_nx  = own_data;
          burst_nx = burst_cnt + 1'b1;
          if (own_last || (burst_cnt == CNT_W'(MAX_BURST - 1))) release_now = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Packet end and burst limit coinciding still yields a single release.
    if (release_now) begin
      state_nx = IDLE;
      rr_nx    = (grant_id == IDX_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      grant_nx = '0;
      busy_nx  = 1'b0;
      burst_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      fifo_write_en <= 1'b0;
      fifo_data     <= '0;
    end else begin
      state         <= state_nx;
      rr_ptr        <= rr_nx;
      burst_cnt     <= burst_nx;
      grant_id      <= grant_nx;
      busy          <= busy_nx;
      fifo_write_en <= wen_nx;
      fifo_data     <= data_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter -- directed scoreboard bench for fifo_write_arbiter.
// Rev 1.0
`default_nettype none

module tb_fifo_write_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 6;
  localparam int MAX_BURST = 4;
  localparam int IDX_W     = 2;

  logic                  clk;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ack;
  logic                  fifo_ready;
  logic                  fifo_write_en;
  logic [WIDTH-1:0]      fifo_data;
  logic [IDX_W-1:0]      grant_id;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb[$];

  fifo_write_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ack(req_ack),
    .fifo_ready(fifo_ready),
    .fifo_write_en(fifo_write_en),
    .fifo_data(fifo_data),
    .grant_id(grant_id),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic set_beat(input int i, input logic [WIDTH-1:0] d, input logic last);
    req_data[i*WIDTH +: WIDTH] = d;
    req_last[i] = last;
  endtask

  // Every FIFO write is matched in order against the expected beats.
  always @(negedge clk) begin
    if (fifo_write_en === 1'b1) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else chk("fifo_data", 32'(fifo_data), 32'(sb.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] d;
    int own;
    reset_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; fifo_ready = 1'b1;

    // Reset state
    cycle(); cycle(); mid();
    chk("rst_wen",   32'(fifo_write_en), 32'd0);
    chk("rst_busy",  32'(busy),          32'd0);
    chk("rst_grant", 32'(grant_id),      32'd0);
    chk("rst_data",  32'(fifo_data),     32'd0);
    chk("rst_ack",   32'(req_ack),       32'd0);

    // Single requester 2, three-beat packet
    cycle(); reset_n = 1'b1; req_valid = 4'b0100; set_beat(2, 6'h11, 1'b0); mid();
    chk("a_idle_ack", 32'(req_ack), 32'd0);
    cycle(); mid();
    chk("a_grant", 32'(grant_id), 32'd2);
    chk("a_busy",  32'(busy),     32'd1);
    chk("a_wen0",  32'(fifo_write_en), 32'd0);
    chk("a_ack1",  32'(req_ack),  32'b0100); sb.push_back(6'h11);
    cycle(); set_beat(2, 6'h22, 1'b0); mid();
    chk("a_ack2", 32'(req_ack), 32'b0100); chk("a_wen1", 32'(fifo_write_en), 32'd1); sb.push_back(6'h22);
    cycle(); set_beat(2, 6'h33, 1'b1); mid();
    chk("a_ack3", 32'(req_ack), 32'b0100); sb.push_back(6'h33);
    cycle(); req_valid = '0; req_last = '0; mid();
    chk("a_rel_busy", 32'(busy), 32'd0); chk("a_rel_grant", 32'(grant_id), 32'd0);
    chk("a_wen3", 32'(fifo_write_en), 32'd1);
    cycle(); mid();
    chk("a_wen_off", 32'(fifo_write_en), 32'd0);

    // Forfeit: rr_ptr=3 picks 3 over 0 and 1; owner 3 drops valid after one beat
    cycle(); req_valid = 4'b1011; set_beat(3, 6'h2a, 1'b0); set_beat(0, 6'h05, 1'b0); set_beat(1, 6'h21, 1'b0); mid();
    chk("b_idle_ack", 32'(req_ack), 32'd0);
    cycle(); mid();
    chk("b_grant", 32'(grant_id), 32'd3); chk("b_ack", 32'(req_ack), 32'b1000); sb.push_back(6'h2a);
    cycle(); req_valid[3] = 1'b0; mid();
    chk("b_forfeit_ack", 32'(req_ack), 32'd0); chk("b_hold_busy", 32'(busy), 32'd1);
    cycle(); mid();
    chk("b_rel_busy", 32'(busy), 32'd0); chk("b_rel_grant", 32'(grant_id), 32'd0);
    chk("b_rel_wen", 32'(fifo_write_en), 32'd0);
    cycle(); set_beat(0, 6'h05, 1'b1); mid();
    chk("b_wrap_grant", 32'(grant_id), 32'd0); chk("b_wrap_busy", 32'(busy), 32'd1);
    chk("b_wrap_ack", 32'(req_ack), 32'b0001); sb.push_back(6'h05);
    cycle(); req_valid[0] = 1'b0; req_last = '0; mid();
    chk("b_end_busy", 32'(busy), 32'd0);

    // Backpressure on owner 1 mid-burst
    cycle(); mid();
    chk("c_grant", 32'(grant_id), 32'd1); chk("c_ack1", 32'(req_ack), 32'b0010); sb.push_back(6'h21);
    cycle(); set_beat(1, 6'h22, 1'b0); mid();
    chk("c_ack2", 32'(req_ack), 32'b0010); sb.push_back(6'h22);
    cycle(); fifo_ready = 1'b0; set_beat(1, 6'h23, 1'b0); mid();
    chk("c_bp_ack0", 32'(req_ack), 32'd0); chk("c_wen_prev", 32'(fifo_write_en), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(); if (i == 2) fifo_ready = 1'b1; mid();
      chk("c_bp_wen",   32'(fifo_write_en), 32'd0);
      chk("c_bp_grant", 32'(grant_id),      32'd1);
      chk("c_bp_busy",  32'(busy),          32'd1);
      chk("c_bp_ack",   32'(req_ack), (i == 2) ? 32'b0010 : 32'd0);
    end
    sb.push_back(6'h23);
    cycle(); set_beat(1, 6'h24, 1'b0); mid();
    chk("c_ack4", 32'(req_ack), 32'b0010); chk("c_wen3", 32'(fifo_write_en), 32'd1); sb.push_back(6'h24);
    cycle(); req_valid = '0; mid();
    chk("c_rel_busy", 32'(busy), 32'd0);

    // Contention between 0 and 1, no last: 4-beat bursts alternate with one idle cycle
    cycle(); req_valid = 4'b0011; set_beat(0, 6'd0, 1'b0); set_beat(1, 6'd1, 1'b0); mid();
    chk("d_idle_ack", 32'(req_ack), 32'd0);
    for (int g = 0; g < 4; g++) begin
      own = g % 2;
      for (int b = 0; b < MAX_BURST; b++) begin
        cycle(); mid();
        chk("d_grant", 32'(grant_id), 32'(own));
        chk("d_ack",   32'(req_ack),  32'(1 << own));
        sb.push_back(WIDTH'(own));
      end
      cycle(); if (g == 3) req_valid = '0; mid();
      chk("d_gap_busy", 32'(busy), 32'd0);
      chk("d_gap_ack",  32'(req_ack), 32'd0);
    end

    // Reset during owner 2's second beat
    cycle(); req_valid = 4'b0101; set_beat(2, 6'h31, 1'b0); set_beat(0, 6'h07, 1'b1); mid();
    cycle(); mid();
    chk("e_grant", 32'(grant_id), 32'd2); sb.push_back(6'h31);
    cycle(); set_beat(2, 6'h32, 1'b0); reset_n = 1'b0; mid();
    chk("e_rst_ack", 32'(req_ack), 32'd0);
    cycle(); reset_n = 1'b1; mid();
    chk("e_wen",   32'(fifo_write_en), 32'd0);
    chk("e_busy",  32'(busy),          32'd0);
    chk("e_grant0", 32'(grant_id),     32'd0);
    cycle(); mid();
    chk("e_regrant", 32'(grant_id), 32'd0); chk("e_rebusy", 32'(busy), 32'd1);
    chk("e_ack", 32'(req_ack), 32'b0001); sb.push_back(6'h07);
    cycle(); req_valid = '0; req_last = '0; mid();
    chk("e_end_busy", 32'(busy), 32'd0);

    // Last on the burst-limit beat: one release, rr_ptr advances once (1 -> 2)
    cycle(); req_valid = 4'b0110; set_beat(1, 6'h15, 1'b0); set_beat(2, 6'h3f, 1'b1); mid();
    for (int b = 0; b < MAX_BURST; b++) begin
      cycle();
      d = WIDTH'(6'h15 + b);
      if (b > 0) set_beat(1, d, (b == MAX_BURST - 1));
      mid();
      chk("f_grant", 32'(grant_id), 32'd1);
      chk("f_ack",   32'(req_ack),  32'b0010);
      sb.push_back(d);
    end
    cycle(); set_beat(1, 6'h20, 1'b0); mid();
    chk("f_rel_busy", 32'(busy), 32'd0); chk("f_rel_wen", 32'(fifo_write_en), 32'd1);
    cycle(); mid();
    chk("f_next_grant", 32'(grant_id), 32'd2); chk("f_next_ack", 32'(req_ack), 32'b0100);
    sb.push_back(6'h3f);
    cycle(); req_valid = '0; req_last = '0; mid();
    cycle(); cycle(); mid();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 6-bit latch/flop FIFO datapath between NREQ on-chip producers.
- Grants one producer at a time and forwards its beats as registered write_en/data pulses.
- Bounds each grant by a burst limit or an end-of-packet marker, so one producer cannot starve the others.
- Sits between the producers and the FIFO write-side input buffer.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 6, data width per beat
MAX_BURST, 4, maximum beats per grant (1..15)
IDX_W, $clog2(NREQ), derived width of requester index

Ports:
clk  input  1  clock
reset_n  input  1  reset, synchronous, active-low
req_valid  input  NREQ  bit i: requester i has a beat on its data slice
req_data  input  NREQ*WIDTH  beat data; requester i on bits [i*WIDTH +: WIDTH]
req_last  input  NREQ  bit i: current beat is the last of requester i's packet
req_ack  output  NREQ  combinational; bit i high means requester i's beat is taken this edge
fifo_ready  input  1  FIFO can accept a write; must keep one entry of slack (see Behaviour)
fifo_write_en  output  1  registered write strobe to FIFO
fifo_data  output  WIDTH  registered write data, valid when fifo_write_en
grant_id  output  IDX_W  registered index of current owner; 0 when idle
busy  output  1  registered; high while in OWN state

Behaviour:
- Reset (synchronous, sampled at posedge clk with reset_n=0): state=IDLE, rr_ptr=0, burst_cnt=0, fifo_write_en=0, fifo_data=0, grant_id=0, busy=0.
  - Reset overrides all other activity, including a transfer in the same cycle; req_ack is all-zero while reset_n=0.
- States: IDLE, OWN. owner is held in grant_id.
- IDLE:
  - If any req_valid bit is set, select the first i scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Next state is OWN with grant_id=i, busy=1, burst_cnt=0.
  - No ack is issued in IDLE, so each grant costs one arbitration cycle.
- OWN, transfer condition T = req_valid[owner] & fifo_ready:
  - req_ack[owner]=T; all other ack bits are 0.
  - On T: next edge sets fifo_write_en=1 and fifo_data=req_data[owner] (latency 1 cycle); burst_cnt increments.
  - Otherwise fifo_write_en=0 next edge; fifo_data holds its last value.
- Release from OWN to IDLE, with rr_ptr=(owner+1) mod NREQ, grant_id=0, busy=0, on any of:
  - (a) T & req_last[owner];
  - (b) T & burst_cnt==MAX_BURST-1;
  - (c) !req_valid[owner]. An owner that drops valid forfeits its grant, and no beat is taken that cycle.
- fifo_ready=0 with req_valid[owner]=1: hold ownership; no ack; burst_cnt unchanged; no timeout.
- Slack rule: the write lands one cycle after fifo_ready is sampled. The FIFO must therefore deassert fifo_ready while it still has at least one free entry. The arbiter does not count occupancy.
- Throughput: at most MAX_BURST beats per MAX_BURST+1 cycles for continuous traffic.
- req_data and req_last are sampled only on the owner's slice and only when T=1.
- Non-owner inputs are ignored while in OWN. No requester is ever acked without ownership.
- Fairness: with all requesters permanently valid, grants rotate 0,1,2,...,NREQ-1,0 starting from reset. Each requester waits at most (NREQ-1)*(MAX_BURST+1)+1 cycles between grants.
- rr_ptr wraps from NREQ-1 to 0. For non-power-of-two NREQ, indices >= NREQ are never selected.

Test Plan:
- Single requester: req 2 sends 0x11,0x22,0x33, last on 0x33, fifo_ready=1 -> grant_id=2 one cycle after valid; fifo_write_en high 3 consecutive cycles with 0x11,0x22,0x33; then IDLE and rr_ptr=3.
- Contention: reqs 0 and 1 valid continuously, each sending beat=index, last never set, MAX_BURST=4 -> FIFO sees 0,0,0,0,(gap),1,1,1,1,(gap),0,... and req_ack never high for both requesters in one cycle.
- Backpressure: owner 1 mid-burst, fifo_ready low 3 cycles -> no ack, no write_en, grant_id stays 1, burst_cnt unchanged; resumes and completes the remaining beats after fifo_ready returns.
- Forfeit: owner 3 drops valid after 1 beat while req 0 is waiting -> release the same cycle, grant_id=0 after one IDLE cycle; wrap 3->0 confirmed.
- Reset mid-burst: reset_n low for 1 cycle during owner 2's second beat -> next cycle fifo_write_en=0, busy=0, grant_id=0; next grant goes to the lowest valid index.
- Packet end vs burst limit in the same beat (req_last on beat 4, MAX_BURST=4) -> exactly one release, 4 writes, rr_ptr advances once.
